// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared register map, CTRL layout, modes and FSM states for timer_counter
package timer_counter_pkg;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_WIDTH    = 4;

    // Only 01 selects auto-reload; 00, 10 and 11 all count once
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef logic [1:0] tc_addr_t;
    typedef logic [1:0] tc_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    function automatic logic is_reload(input tc_mode_t mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - CPU bridge register port of the timer
interface timer_counter_if;
    import timer_counter_pkg::*;

    tc_addr_t    Addr;
    logic        WE;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output WData,
        input  RData,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  WData,
        output RData,
        output IRQ
    );

endinterface

// File: rtl/timer_counter_prescaler.sv
// rtl/timer_counter_prescaler.sv - count-step prescaler, built only with TC_PRESCALE_EN
`ifdef TC_PRESCALE_EN
module timer_counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    assign tick = run && (cnt == LAST);

    // Free-running divider while counting; restarts from 0 on every reload
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - programmable countdown timer with one-shot/auto-reload IRQ (option: TC_PRESCALE_EN)
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    tc_state_e                state, state_n;
    logic [CTRL_WIDTH-1:0]    ctrl, ctrl_n;
    logic [31:0]              preset, preset_n;
    logic [31:0]              count, count_n;
    logic                     pending, pending_n;
    logic                     step;

    // Reject out-of-range divider settings at elaboration
    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("timer_counter: PRESCALE out of range 1..65535");
        end
    endgenerate

`ifdef TC_PRESCALE_EN
    timer_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_LOAD),
        .run   (state == ST_CNT),
        .tick  (step)
    );
`else
    assign step = 1'b1;
`endif

    // Next-state logic: FSM update first, then a CPU write on top so software wins any collision
    always_comb begin
        state_n   = state;
        ctrl_n    = ctrl;
        preset_n  = preset;
        count_n   = count;
        pending_n = pending;

        unique case (state)
            ST_IDLE: begin
                if (ctrl[CTRL_EN_BIT]) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_n = preset;
                state_n = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl[CTRL_EN_BIT]) begin
                    state_n = ST_IDLE;
                end else if (step) begin
                    // COUNT of 0 or 1 both expire, so PRESET=0 acts like 1
                    if (count > 32'd1) begin
                        count_n = count - 32'd1;
                    end else begin
                        count_n   = '0;
                        pending_n = 1'b1;
                        state_n   = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (is_reload(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB])) begin
                    pending_n = 1'b0;
                    state_n   = ST_LOAD;
                end else begin
                    ctrl_n[CTRL_EN_BIT] = 1'b0;
                    state_n             = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (bus.WE) begin
            case (bus.Addr)
                TC_CTRL: begin
                    ctrl_n    = bus.WData[CTRL_WIDTH-1:0];
                    pending_n = 1'b0;
                end
                TC_PRESET: preset_n = bus.WData;
                default: ;
            endcase
        end
    end

    // Register update; reset beats any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            ctrl    <= ctrl_n;
            preset  <= preset_n;
            count   <= count_n;
            pending <= pending_n;
        end
    end

    // Side-effect-free read mux
    always_comb begin
        bus.RData = '0;
        case (bus.Addr)
            TC_CTRL:   bus.RData = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
            TC_PRESET: bus.RData = preset;
            TC_COUNT:  bus.RData = count;
            default:   bus.RData = '0;
        endcase
    end

    assign bus.IRQ = ctrl[CTRL_IM_BIT] & pending;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter against a timing-formula model
module tb_timer_counter;
    import timer_counter_pkg::*;

`ifdef TC_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    timer_counter_if bus();

    timer_counter #(
        .PRESCALE (PS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr  = a;
        bus.WData = d;
        bus.WE    = 1'b1;
        @(posedge clk);
        #1;
        bus.WE    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.RData;
    endtask

    task automatic do_reset();
        bus.WE = 1'b0;
        reset  = 1'b1;
        step();
        step();
        reset  = 1'b0;
    endtask

    // k2 = edges since the LOAD edge. Counting lasts max(N,1)*PS edges,
    // decrementing once every PS edges; auto-reload adds INT + LOAD cycles.
    function automatic int phase(input int n, input bit rl, input int k2);
        int len;
        len = (n < 1 ? 1 : n) * PS;
        return rl ? (k2 % (len + 2)) : k2;
    endfunction

    function automatic logic [31:0] m_count(input int n, input bit rl, input int k2);
        int len, p, d;
        len = (n < 1 ? 1 : n) * PS;
        p   = phase(n, rl, k2);
        if (p >= len) return 32'd0;
        d = p / PS;
        return (d < n) ? 32'(n - d) : 32'd0;
    endfunction

    function automatic logic m_pending(input int n, input bit rl, input int k2);
        int len;
        len = (n < 1 ? 1 : n) * PS;
        return rl ? (phase(n, rl, k2) == len) : (k2 >= len);
    endfunction

    function automatic logic m_enable(input int n, input bit rl, input int k2);
        int len;
        len = (n < 1 ? 1 : n) * PS;
        return rl ? 1'b1 : (k2 <= len);
    endfunction

    // Reset, program PRESET and CTRL, then check COUNT/IRQ/CTRL after every edge
    task automatic run_scenario(input int n, input logic [1:0] mode, input logic im, input int ncyc);
        logic [31:0] d;
        logic [31:0] exp_cnt;
        logic        exp_irq, exp_en;
        bit          rl;
        int          k2;
        rl = (mode == 2'b01);
        do_reset();
        wr(TC_PRESET, 32'(n));
        rd(TC_PRESET, d);
        chk($sformatf("preset_rd n%0d", n), d, 32'(n));
        wr(TC_CTRL, {28'd0, im, mode, 1'b1});
        for (int j = 1; j <= ncyc; j++) begin
            step();
            k2 = j - 2;
            if (k2 < 0) begin
                exp_cnt = 32'd0;
                exp_irq = 1'b0;
                exp_en  = 1'b1;
            end else begin
                exp_cnt = m_count(n, rl, k2);
                exp_irq = im & m_pending(n, rl, k2);
                exp_en  = m_enable(n, rl, k2);
            end
            rd(TC_COUNT, d);
            chk($sformatf("count n%0d m%0d j%0d", n, mode, j), d, exp_cnt);
            chk($sformatf("irq n%0d m%0d j%0d", n, mode, j), {31'd0, bus.IRQ}, {31'd0, exp_irq});
            rd(TC_CTRL, d);
            chk($sformatf("ctrl n%0d m%0d j%0d", n, mode, j), d, {28'd0, im, mode, exp_en});
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n, len;

        bus.Addr  = TC_CTRL;
        bus.WE    = 1'b0;
        bus.WData = '0;

        // Reset state
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk($sformatf("reset_rd a%0d", a), d, 32'd0);
        end
        chk("reset_irq", {31'd0, bus.IRQ}, 32'd0);

        // One-shot with held IRQ, then software acknowledge
        run_scenario(5, 2'b00, 1'b1, 5 * PS + 22);
        wr(TC_CTRL, 32'h8);
        chk("ack_irq", {31'd0, bus.IRQ}, 32'd0);
        rd(TC_CTRL, d);
        chk("ack_ctrl", d, 32'h8);

        // Auto-reload pulses
        run_scenario(3, 2'b01, 1'b1, 3 * (3 * PS + 2) + 2);

        // Masked expiry: later IM set must not reveal the lost event
        run_scenario(4, 2'b00, 1'b0, 4 * PS + 6);
        wr(TC_CTRL, 32'h8);
        chk("masked_irq0", {31'd0, bus.IRQ}, 32'd0);
        step();
        chk("masked_irq1", {31'd0, bus.IRQ}, 32'd0);

        // Mode 10 behaves as one-shot; PRESET=0 behaves as 1
        run_scenario(2, 2'b10, 1'b1, 2 * PS + 6);
        run_scenario(0, 2'b01, 1'b1, 3 * (PS + 2) + 2);

        // Randomized programs
        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(9, 0));
            len = (n < 1 ? 1 : n) * PS;
            run_scenario(n, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 2 * (len + 2) + 2);
        end

        // Disable mid-count freezes COUNT; re-enable reloads
        do_reset();
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'h9);
        for (int j = 0; j < 2 + 4 * PS; j++) step();
        rd(TC_COUNT, d);
        chk("dis_cnt6", d, 32'd6);
        for (int j = 0; j < PS - 1; j++) step();
        wr(TC_CTRL, 32'h8);
        rd(TC_COUNT, d);
        chk("dis_cnt5", d, 32'd5);
        step(); step(); step();
        rd(TC_COUNT, d);
        chk("dis_frozen", d, 32'd5);
        chk("dis_irq", {31'd0, bus.IRQ}, 32'd0);
        wr(TC_CTRL, 32'h9);
        step();
        rd(TC_COUNT, d);
        chk("reen_load_wait", d, 32'd5);
        step();
        rd(TC_COUNT, d);
        chk("reen_reload", d, 32'd10);

        // PRESET write mid-count only takes effect at the next LOAD
        do_reset();
        wr(TC_PRESET, 32'd6);
        wr(TC_CTRL, 32'h9);
        step(); step(); step();
        wr(TC_PRESET, 32'd2);
        rd(TC_COUNT, d);
        chk("pre_mid_cnt", d, (PS == 1) ? 32'd4 : 32'd6);
        for (int j = 0; j < 6 * PS - 2; j++) step();
        rd(TC_COUNT, d);
        chk("pre_old_exp_cnt", d, 32'd0);
        chk("pre_old_exp_irq", {31'd0, bus.IRQ}, 32'd1);
        wr(TC_CTRL, 32'h9);
        step(); step();
        rd(TC_COUNT, d);
        chk("pre_new_load", d, 32'd2);

        // Reset mid-count overrides a same-cycle write
        do_reset();
        wr(TC_PRESET, 32'd7);
        wr(TC_CTRL, 32'hB);
        step(); step(); step(); step();
        bus.Addr  = TC_CTRL;
        bus.WData = 32'h9;
        bus.WE    = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        bus.WE    = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk($sformatf("midreset_rd a%0d", a), d, 32'd0);
        end
        chk("midreset_irq", {31'd0, bus.IRQ}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
